// File: rtl/crp16_mem_loader.sv
// UART (8N1) boot loader: receives a big-endian word count N then N big-endian words, writes them to 0..N-1.
// Latency: mem_wren asserts one cycle after the stop bit of each word's low byte is accepted.
// Backpressure: none; the serial line cannot be stalled, and writes complete long before the next byte ends.
//
// Ports:
//   clock, reset_n      system clock, asynchronous active-low reset
//   rx                  asynchronous UART line (idle high)
//   load_req            single-cycle request to start a new session (honoured only when done)
//   mem_address/_data   memory write port, mem_wren one-cycle strobe per word
//   cpu_hold            processor held in reset while high (everything except DONE)
//   load_done           session complete; frame_error: bad stop bit seen (sticky until reset)
//   words_left          words still expected in the current session
module crp16_mem_loader #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx,
    input  logic        load_req,
    output logic [15:0] mem_address,
    output logic [15:0] mem_data,
    output logic        mem_wren,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        frame_error,
    output logic [15:0] words_left
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_DONE, S_ERROR
    } ses_state_t;

    // ---------------- synchronizer ----------------
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // ---------------- receiver ----------------
    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        byte_valid, byte_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = 16'd0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                // Re-check the line at mid start bit; a glitch has already returned high.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = 16'd0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = 16'd0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};  // LSB arrives first
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = 16'd0;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_LAST) && rx_sync_q;
        byte_err   = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_LAST) && !rx_sync_q;
    end

    // ---------------- session ----------------
    ses_state_t  ses_q, ses_d;
    logic [7:0]  hi_byte_q, hi_byte_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [15:0] words_left_q, words_left_d;
    logic [15:0] mem_address_q, mem_address_d;
    logic [15:0] mem_data_q, mem_data_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ses_q         <= S_LEN_HI;
            hi_byte_q     <= 8'd0;
            word_idx_q    <= 16'd0;
            words_left_q  <= 16'd0;
            mem_address_q <= 16'd0;
            mem_data_q    <= 16'd0;
        end else begin
            ses_q         <= ses_d;
            hi_byte_q     <= hi_byte_d;
            word_idx_q    <= word_idx_d;
            words_left_q  <= words_left_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
        end
    end

    always_comb begin
        ses_d         = ses_q;
        hi_byte_d     = hi_byte_q;
        word_idx_d    = word_idx_q;
        words_left_d  = words_left_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        if (byte_err && ses_q != S_DONE) begin
            ses_d = S_ERROR;
        end else begin
            case (ses_q)
                S_LEN_HI: if (byte_valid) begin
                    hi_byte_d = rx_shift_q;
                    ses_d     = S_LEN_LO;
                end
                S_LEN_LO: if (byte_valid) begin
                    words_left_d = {hi_byte_q, rx_shift_q};
                    ses_d = ({hi_byte_q, rx_shift_q} == 16'd0) ? S_DONE : S_DATA_HI;
                end
                S_DATA_HI: if (byte_valid) begin
                    hi_byte_d = rx_shift_q;
                    ses_d     = S_DATA_LO;
                end
                S_DATA_LO: if (byte_valid) begin
                    // Latch the write port on the way into WRITE so it holds afterwards.
                    mem_address_d = word_idx_q;
                    mem_data_d    = {hi_byte_q, rx_shift_q};
                    ses_d         = S_WRITE;
                end
                S_WRITE: begin
                    word_idx_d   = word_idx_q + 16'd1;   // wraps freely
                    words_left_d = words_left_q - 16'd1;
                    ses_d = (words_left_q == 16'd1) ? S_DONE : S_DATA_HI;
                end
                S_DONE: if (load_req) begin
                    word_idx_d   = 16'd0;
                    words_left_d = 16'd0;
                    ses_d        = S_LEN_HI;
                end
                S_ERROR: ses_d = S_ERROR;
                default: ses_d = S_ERROR;
            endcase
        end
    end

    always_comb begin
        mem_wren    = (ses_q == S_WRITE);
        cpu_hold    = (ses_q != S_DONE);
        load_done   = (ses_q == S_DONE);
        frame_error = (ses_q == S_ERROR);
    end

    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign words_left  = words_left_q;

endmodule

// File: tb/tb_crp16_mem_loader.sv
module tb_crp16_mem_loader;

    localparam int CPB = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        rx = 1'b1;
    logic        load_req = 1'b0;
    logic [15:0] mem_address, mem_data, words_left;
    logic        mem_wren, cpu_hold, load_done, frame_error;

    always #5 clock = ~clock;

    crp16_mem_loader #(.CLKS_PER_BIT(CPB)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx          (rx),
        .load_req    (load_req),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .frame_error (frame_error),
        .words_left  (words_left)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (byte-count view of a session) ----------------
    logic [7:0]  m_bytes[$];
    int          m_n = 0;
    bit          m_done = 0;
    bit          m_err = 0;
    logic [15:0] m_last_addr = 16'd0;
    logic [15:0] m_last_data = 16'd0;
    logic [31:0] exp_q[$];
    logic [31:0] act_log[$];

    function automatic void model_reset();
        m_bytes.delete();
        m_n = 0; m_done = 0; m_err = 0;
        m_last_addr = 16'd0; m_last_data = 16'd0;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit ok);
        int sz;
        logic [15:0] a, d;
        if (m_done || m_err) return;
        if (!ok) begin m_err = 1; return; end
        m_bytes.push_back(b);
        sz = m_bytes.size();
        if (sz == 2) begin
            m_n = {m_bytes[0], m_bytes[1]};
            if (m_n == 0) m_done = 1;
        end else if (sz >= 4 && sz % 2 == 0) begin
            a = 16'((sz - 4) / 2);
            d = {m_bytes[sz-2], m_bytes[sz-1]};
            exp_q.push_back({a, d});
            m_last_addr = a; m_last_data = d;
            if ((sz - 2) / 2 == m_n) m_done = 1;
        end
    endfunction

    function automatic logic [15:0] model_words_left();
        int sz = m_bytes.size();
        if (sz < 2) return 16'd0;
        return 16'(m_n - (sz - 2) / 2);
    endfunction

    // ---------------- per-cycle compare process ----------------
    logic wren_prev = 1'b0;
    always @(negedge clock) begin
        logic [31:0] e;
        chk("hold_vs_done", {31'd0, cpu_hold}, {31'd0, !load_done});
        chk("done_err_exclusive", {31'd0, load_done & frame_error}, 32'd0);
        chk("wren_single_cycle", {31'd0, mem_wren & wren_prev}, 32'd0);
        if (mem_wren) begin
            act_log.push_back({mem_address, mem_data});
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_address, mem_data);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", {16'd0, mem_address}, {16'd0, e[31:16]});
                chk("write_data", {16'd0, mem_data}, {16'd0, e[15:0]});
            end
        end
        wren_prev = mem_wren;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".load_done"},   {31'd0, load_done},   {31'd0, m_done});
        chk({tag, ".frame_error"}, {31'd0, frame_error}, {31'd0, m_err});
        chk({tag, ".cpu_hold"},    {31'd0, cpu_hold},    {31'd0, !m_done});
        chk({tag, ".words_left"},  {16'd0, words_left},  {16'd0, model_words_left()});
        chk({tag, ".mem_address"}, {16'd0, mem_address}, {16'd0, m_last_addr});
        chk({tag, ".mem_data"},    {16'd0, mem_data},    {16'd0, m_last_data});
        chk({tag, ".writes_drained"}, exp_q.size(), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        rx = 1'b0; cyc(CPB);
        for (int i = 0; i < 8; i++) begin rx = b[i]; cyc(CPB); end
        rx = ok; cyc(CPB);
        model_byte(b, ok);
        rx = 1'b1;
        cyc(6 + int'($urandom_range(0, 3)));
        check_state("byte");
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1; cyc(1); load_req = 1'b0;
        if (m_done) begin m_done = 0; m_bytes.delete(); m_n = 0; end
        cyc(2);
        check_state("load_req");
    endtask

    task automatic glitch();
        rx = 1'b0; cyc(1); rx = 1'b1; cyc(8);
        check_state("glitch");
    endtask

    task automatic do_reset();
        reset_n = 1'b0; rx = 1'b1; #1;
        chk("rst.mem_address", {16'd0, mem_address}, 32'd0);
        chk("rst.mem_data",    {16'd0, mem_data},    32'd0);
        chk("rst.mem_wren",    {31'd0, mem_wren},    32'd0);
        chk("rst.words_left",  {16'd0, words_left},  32'd0);
        chk("rst.cpu_hold",    {31'd0, cpu_hold},    32'd1);
        chk("rst.load_done",   {31'd0, load_done},   32'd0);
        chk("rst.frame_error", {31'd0, frame_error}, 32'd0);
        model_reset();
        cyc(3);
        reset_n = 1'b1;
        cyc(3);
        check_state("after_reset");
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int r;
        logic [7:0] b;
        #2;
        do_reset();

        // Two-word load
        act_log.delete();
        send_byte(8'h00, 1); send_byte(8'h02, 1);
        send_byte(8'h12, 1); send_byte(8'h34, 1);
        send_byte(8'hAB, 1); send_byte(8'hCD, 1);
        chk("two_word.count", act_log.size(), 32'd2);
        chk("two_word.w0", act_log[0], 32'h0000_1234);
        chk("two_word.w1", act_log[1], 32'h0001_ABCD);
        chk("two_word.load_done", {31'd0, load_done}, 32'd1);
        chk("two_word.cpu_hold",  {31'd0, cpu_hold},  32'd0);

        // Reload after DONE
        pulse_load_req();
        chk("reload.cpu_hold", {31'd0, cpu_hold}, 32'd1);
        send_byte(8'h00, 1); send_byte(8'h01, 1);
        send_byte(8'h55, 1); send_byte(8'hAA, 1);
        chk("reload.w0", act_log[act_log.size()-1], 32'h0000_55AA);
        chk("reload.load_done", {31'd0, load_done}, 32'd1);

        // Bytes ignored in DONE, then zero-length session
        send_byte(8'h77, 1);
        send_byte(8'h66, 0);
        pulse_load_req();
        r = act_log.size();
        send_byte(8'h00, 1); send_byte(8'h00, 1);
        chk("zero_len.no_write", act_log.size(), r);
        chk("zero_len.cpu_hold", {31'd0, cpu_hold}, 32'd0);

        // Framing error is sticky
        pulse_load_req();
        send_byte(8'h00, 1); send_byte(8'h01, 1);
        send_byte(8'h99, 0);
        chk("ferr.frame_error", {31'd0, frame_error}, 32'd1);
        chk("ferr.cpu_hold",    {31'd0, cpu_hold},    32'd1);
        pulse_load_req();
        send_byte(8'h12, 1); send_byte(8'h34, 1);
        chk("ferr.no_write", act_log.size(), r);
        chk("ferr.sticky", {31'd0, frame_error}, 32'd1);
        do_reset();

        // Glitch while idle, then a valid frame
        glitch();
        act_log.delete();
        send_byte(8'h00, 1); send_byte(8'h01, 1);
        send_byte(8'hBE, 1); send_byte(8'hEF, 1);
        chk("glitch.count", act_log.size(), 32'd1);
        chk("glitch.w0", act_log[0], 32'h0000_BEEF);

        // Reset in the middle of the second data byte
        pulse_load_req();
        r = act_log.size();
        send_byte(8'h00, 1); send_byte(8'h01, 1); send_byte(8'h12, 1);
        rx = 1'b0; cyc(CPB);
        for (int i = 0; i < 3; i++) begin rx = 1'b1; cyc(CPB); end
        do_reset();
        chk("midreset.no_write", act_log.size(), r);
        send_byte(8'h00, 1); send_byte(8'h01, 1);
        send_byte(8'hC3, 1); send_byte(8'h3C, 1);
        chk("midreset.reload", act_log[act_log.size()-1], 32'h0000_C33C);

        // Maximum length header
        pulse_load_req();
        send_byte(8'hFF, 1); send_byte(8'hFF, 1);
        chk("maxlen.words_left", {16'd0, words_left}, 32'h0000_FFFF);
        send_byte(8'h11, 1); send_byte(8'h22, 1);
        chk("maxlen.words_left_after", {16'd0, words_left}, 32'h0000_FFFE);
        do_reset();

        // Randomized traffic
        for (int it = 0; it < 150; it++) begin
            r = int'($urandom_range(0, 11));
            if (m_done && r < 5) begin
                pulse_load_req();
            end else if (r < 9) begin
                if (m_bytes.size() == 0)      b = 8'h00;
                else if (m_bytes.size() == 1) b = 8'($urandom_range(0, 3));
                else                          b = 8'($urandom_range(0, 255));
                send_byte(b, $urandom_range(0, 24) != 0);
            end else if (r == 9) begin
                glitch();
            end else if (r == 10) begin
                pulse_load_req();
            end else if (m_err || $urandom_range(0, 3) == 0) begin
                do_reset();
            end
        end

        cyc(10);
        chk("final.writes_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
